// File: rtl/button_pkg.sv
// Shared types and default timing constants for push-button conditioning.
// Every button instance in the game datapath pulls its defaults from here.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REL_CHK
    } btn_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 16;
    localparam int DEFAULT_REPEAT_DELAY    = 64;
    localparam int DEFAULT_REPEAT_PERIOD   = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for one asynchronous input pin.
// Reused for every raw pin that enters the clk domain.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/button_conditioner.sv
// Turns a raw push-button level into a debounced held level plus press,
// auto-repeat and release strobes, all registered.
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic pulse,
    output logic held,
    output logic release_pulse
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD)) + 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic             btn_sync;
    btn_state_t       state_q;
    logic [DB_W-1:0]  db_cnt_q;
    logic [RPT_W-1:0] rpt_cnt_q;
    logic             first_done_q;
    logic             pulse_q;
    logic             held_q;
    logic             release_q;
    logic [RPT_W-1:0] rpt_last;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn_raw),
        .q_o (btn_sync)
    );

    // The first repeat waits the long delay, later ones the short period.
    assign rpt_last = first_done_q ? PER_LAST : DLY_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            db_cnt_q     <= '0;
            rpt_cnt_q    <= '0;
            first_done_q <= 1'b0;
            pulse_q      <= 1'b0;
            held_q       <= 1'b0;
            release_q    <= 1'b0;
        end else begin
            pulse_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (btn_sync) begin
                        state_q  <= PRESS_CHK;
                        db_cnt_q <= '0;
                    end
                end
                PRESS_CHK: begin
                    if (!btn_sync) begin
                        state_q <= IDLE;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q      <= HELD;
                        pulse_q      <= 1'b1;
                        held_q       <= 1'b1;
                        rpt_cnt_q    <= '0;
                        first_done_q <= 1'b0;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                HELD: begin
                    if (!btn_sync) begin
                        state_q  <= REL_CHK;
                        db_cnt_q <= '0;
                    end else if (!repeat_en) begin
                        rpt_cnt_q <= '0;
                    end else if (rpt_cnt_q == rpt_last) begin
                        pulse_q      <= 1'b1;
                        rpt_cnt_q    <= '0;
                        first_done_q <= 1'b1;
                    end else begin
                        rpt_cnt_q <= rpt_cnt_q + RPT_W'(1);
                    end
                end
                REL_CHK: begin
                    // A bounce back to pressed resumes the hold without a new press.
                    if (btn_sync) begin
                        state_q   <= HELD;
                        rpt_cnt_q <= '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_q   <= IDLE;
                        release_q <= 1'b1;
                        held_q    <= 1'b0;
                    end else begin
                        db_cnt_q <= db_cnt_q + DB_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pulse         = pulse_q;
    assign held          = held_q;
    assign release_pulse = release_q;

endmodule
